l2_cache_meta_update_stage: RTL and testbench
=============================================

Name: l2_cache_meta_update_stage

Overview:
- Consumes the per-way tag, valid and dirty lookup results that the L2 tag stage produces one cycle after arbitration.
- Resolves hit and hit way, and drives the same-cycle tag, valid, dirty and LRU update buses back into the tag stage.
- Queues dirty victims and flushed lines in a writeback address queue with valid/ready handshake toward the L2 bus interface.
- Sits in parallel with the data-array read stage. Registers hit/way results for the following stage.

Parameters:
WB_QUEUE_DEPTH, 8, writeback address queue entries (power of two, >=4)
WB_ALMOST_FULL_MARGIN, 3, free-slot threshold at which almost_full asserts (covers in-flight pipeline requests)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
l2t_request_valid  in  1  tag-stage request valid
l2t_request  in  l2req_packet_t  request packet (packet_type, adress.tag, adress.set_idx)
l2t_valid  in  [L2_WAYS]x1  per-way line valid
l2t_tag  in  [L2_WAYS] x l2_tag_t  per-way stored tag
l2t_dirty  in  [L2_WAYS]x1  per-way dirty
l2t_l2_fill  in  1  request is a memory fill
l2t_fill_way  in  l2_way_idx_t  victim way chosen by LRU
l2u_update_tag_en  out  L2_WAYS  per-way tag/valid write enable (combinational)
l2u_update_tag_set  out  l2_set_idx_t  set for the tag write
l2u_update_tag_valid  out  1  new valid bit
l2u_update_tag_value  out  l2_tag_t  new tag
l2u_update_dirty_en  out  L2_WAYS  per-way dirty write enable (combinational)
l2u_update_dirty_set  out  l2_set_idx_t  set for the dirty write
l2u_update_dirty_value  out  1  new dirty bit
l2u_update_lru_en  out  1  LRU touch (combinational)
l2u_update_lru_hit_way  out  l2_way_idx_t  way to touch
l2u_request_valid  out  1  registered request valid
l2u_hit  out  1  registered hit
l2u_hit_way  out  l2_way_idx_t  registered hit way, or fill way on a fill
l2u_wb_valid  out  1  writeback queue head valid
l2u_wb_entry  out  l2_wb_entry_t  head entry {tag, set_idx, way}
l2u_wb_ready  in  1  consumer accepts head
l2u_wb_almost_full  out  1  arbiter must stop issuing fills and flushes

Behaviour:
- Hit detection:
  - hit_vec[w] = l2t_valid[w] & (l2t_tag[w] == l2t_request.adress.tag).
  - hit = |hit_vec, qualified by l2t_request_valid and !l2t_l2_fill.
  - More than one hit bit set is an assertion failure.
- All update outputs are combinational from l2t_* and are zero when l2t_request_valid=0. Set outputs always equal l2t_request.adress.set_idx.
- Fill (l2t_l2_fill=1):
  - tag_en = onehot(fill_way), tag_valid=1, tag_value = request tag.
  - dirty_en = onehot(fill_way), dirty_value = (packet_type==L2REQ_STORE).
  - lru_en=0, because the tag stage already updated LRU on the fill.
  - If l2t_valid[fill_way] & l2t_dirty[fill_way]: push {l2t_tag[fill_way], set, fill_way} to the queue.
- Store hit: dirty_en = onehot(hit_way), dirty_value=1; lru_en=1.
- Load hit: lru_en=1 with hit_way; no tag or dirty write.
- Flush hit with dirty=1: push {request tag, set, hit_way}; dirty_en = onehot(hit_way), value 0; no LRU touch. Flush miss or clean hit: no action.
- DINVALIDATE hit: tag_en = onehot(hit_way), tag_valid=0; no writeback; no LRU touch.
- Miss on load or store (non-fill): no updates; l2u_hit=0.
- Registered outputs update every cycle with latency 1: l2u_request_valid, l2u_hit, l2u_hit_way (fill_way when fill).
- Writeback queue:
  - Circular buffer with read/write pointers and a count of width $clog2(DEPTH)+1.
  - Push and pop in the same cycle leaves count unchanged.
  - Pop occurs when l2u_wb_valid & l2u_wb_ready.
  - Pointers wrap at DEPTH.
  - l2u_wb_almost_full = (DEPTH - count) <= WB_ALMOST_FULL_MARGIN.
  - Push while full is an assertion failure; the entry is dropped and state is unchanged.
  - Pop when empty is ignored.
  - Head entry is stable while l2u_wb_valid=1 and not popped.
- Reset values: l2u_request_valid=0, l2u_hit=0, l2u_hit_way=0, count=0, pointers=0, l2u_wb_valid=0, l2u_wb_almost_full=0. Reset clears the queue mid-operation; entries in flight are discarded.

Decomposition:
- defines package: l2_wb_entry_t {l2_tag_t tag; l2_set_idx_t set_idx; l2_way_idx_t way}.
- Reuse the existing L2 typedefs and L2REQ_* packet-type constants.
- One sub-module: l2_writeback_queue (parameterized FIFO with count, almost_full, synchronous reset).
- Onehot-to-index conversion uses the existing shared encoder.

Test Plan:
- Load, 4 ways, way 2 valid with tag 0x1234, request tag 0x1234 set 5 -> lru_en=1, hit_way=2; next cycle l2u_hit=1, l2u_hit_way=2; no tag or dirty enable.
- Store hit on way 1 set 9 -> dirty_en=4'b0010, dirty_set=9, dirty_value=1, lru_en=1.
- Fill way 3, victim valid+dirty with tag 0xABC, new tag 0x55, store -> tag_en=4'b1000, tag_value=0x55, dirty_value=1; wb_valid next cycle with {0xABC, set, 3}.
- Flush hit dirty way 0 -> queue push {tag, set, 0}, dirty cleared; flush of clean line -> no push.
- Hold wb_ready=0, push 5 entries (DEPTH 8, margin 3) -> almost_full=1 after the 5th push; pop plus push in the same cycle -> count stays 5; drain -> entries returned in FIFO order, wb_valid=0 at empty.
- Assert reset with 3 queued entries -> next cycle wb_valid=0, almost_full=0, l2u_request_valid=0.

Source files
------------

// File: rtl/l2_cache_meta_update_stage_pkg.sv
// Shared L2 types for the tag/meta pipeline: request packet, per-way tag/index types,
// writeback entry layout, plus the onehot/index helpers used across the L2.
package l2_cache_meta_update_stage_pkg;

  localparam int unsigned L2_WAYS      = 4;
  localparam int unsigned L2_WAY_IDX_W = $clog2(L2_WAYS);
  localparam int unsigned L2_TAG_W     = 16;
  localparam int unsigned L2_SET_IDX_W = 6;

  typedef logic [L2_TAG_W-1:0]     l2_tag_t;
  typedef logic [L2_SET_IDX_W-1:0] l2_set_idx_t;
  typedef logic [L2_WAY_IDX_W-1:0] l2_way_idx_t;
  typedef logic [L2_WAYS-1:0]      l2_way_mask_t;

  typedef enum logic [1:0] {
    L2REQ_LOAD        = 2'd0,
    L2REQ_STORE       = 2'd1,
    L2REQ_FLUSH       = 2'd2,
    L2REQ_DINVALIDATE = 2'd3
  } l2req_packet_type_t;

  typedef struct packed {
    l2_tag_t     tag;
    l2_set_idx_t set_idx;
  } l2_addr_t;

  typedef struct packed {
    l2req_packet_type_t packet_type;
    l2_addr_t           adress;
  } l2req_packet_t;

  typedef struct packed {
    l2_tag_t     tag;
    l2_set_idx_t set_idx;
    l2_way_idx_t way;
  } l2_wb_entry_t;

  // Shared onehot encoder: OR-reduction of set-bit indices.
  function automatic l2_way_idx_t l2_oh_to_idx(input l2_way_mask_t oh);
    l2_way_idx_t idx;
    idx = '0;
    for (int unsigned i = 0; i < L2_WAYS; i++) begin
      if (oh[i]) idx = idx | L2_WAY_IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic l2_way_mask_t l2_idx_to_oh(input l2_way_idx_t idx);
    return L2_WAYS'(1) << idx;
  endfunction

endpackage

// File: rtl/l2_writeback_queue.sv
// Circular FIFO of writeback addresses toward the L2 bus interface, with registered
// valid and almost_full so the arbiter can stop issuing fills/flushes in time.
module l2_writeback_queue
  import l2_cache_meta_update_stage_pkg::*;
#(
  parameter int unsigned DEPTH              = 8,
  parameter int unsigned ALMOST_FULL_MARGIN = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  l2_wb_entry_t i_push_entry,
  output logic         o_valid,
  output l2_wb_entry_t o_entry,
  input  logic         i_ready,
  output logic         o_almost_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  l2_wb_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;
  logic             r_almost_full;

  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;
  logic [CNT_W-1:0] w_count_nxt;

  // A push into a full queue is dropped; pop on empty cannot happen since r_valid gates it.
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_push = i_push & ~w_full;
  assign w_do_pop  = r_valid & i_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_valid       <= 1'b0;
      r_almost_full <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count       <= w_count_nxt;
      r_valid       <= (w_count_nxt != '0);
      r_almost_full <= ((CNT_W'(DEPTH) - w_count_nxt) <= CNT_W'(ALMOST_FULL_MARGIN));
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_entry;
  end

  assign o_valid       = r_valid;
  assign o_entry       = r_mem[r_rd_ptr];
  assign o_almost_full = r_almost_full;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset) !(i_push && w_full));

endmodule

// File: rtl/l2_cache_meta_update_stage.sv
// L2 meta update stage: resolves hit/way from tag lookup, drives same-cycle tag/dirty/LRU
// writes back into the tag stage, and queues dirty victims / flushed lines for writeback.
module l2_cache_meta_update_stage
  import l2_cache_meta_update_stage_pkg::*;
#(
  parameter int unsigned WB_QUEUE_DEPTH        = 8,
  parameter int unsigned WB_ALMOST_FULL_MARGIN = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   l2t_request_valid,
  input  l2req_packet_t          l2t_request,
  input  logic [L2_WAYS-1:0]     l2t_valid,
  input  l2_tag_t [L2_WAYS-1:0]  l2t_tag,
  input  logic [L2_WAYS-1:0]     l2t_dirty,
  input  logic                   l2t_l2_fill,
  input  l2_way_idx_t            l2t_fill_way,
  output logic [L2_WAYS-1:0]     l2u_update_tag_en,
  output l2_set_idx_t            l2u_update_tag_set,
  output logic                   l2u_update_tag_valid,
  output l2_tag_t                l2u_update_tag_value,
  output logic [L2_WAYS-1:0]     l2u_update_dirty_en,
  output l2_set_idx_t            l2u_update_dirty_set,
  output logic                   l2u_update_dirty_value,
  output logic                   l2u_update_lru_en,
  output l2_way_idx_t            l2u_update_lru_hit_way,
  output logic                   l2u_request_valid,
  output logic                   l2u_hit,
  output l2_way_idx_t            l2u_hit_way,
  output logic                   l2u_wb_valid,
  output l2_wb_entry_t           l2u_wb_entry,
  input  logic                   l2u_wb_ready,
  output logic                   l2u_wb_almost_full
);

  l2_way_mask_t w_hit_vec;
  logic         w_hit;
  l2_way_idx_t  w_hit_way;
  l2_way_idx_t  w_resp_way;
  logic         w_wb_push;
  l2_wb_entry_t w_wb_push_entry;

  logic         r_request_valid;
  logic         r_hit;
  l2_way_idx_t  r_hit_way;

  always_comb begin
    w_hit_vec = '0;
    for (int unsigned w = 0; w < L2_WAYS; w++) begin
      w_hit_vec[w] = l2t_valid[w] & (l2t_tag[w] == l2t_request.adress.tag);
    end
  end

  assign w_hit     = l2t_request_valid & ~l2t_l2_fill & (|w_hit_vec);
  assign w_hit_way = l2_oh_to_idx(w_hit_vec);

  // Fills report the victim way so the data stage knows where the line landed.
  assign w_resp_way = (l2t_request_valid && l2t_l2_fill) ? l2t_fill_way :
                      w_hit ? w_hit_way : '0;

  assign l2u_update_tag_set   = l2t_request.adress.set_idx;
  assign l2u_update_dirty_set = l2t_request.adress.set_idx;

  always_comb begin
    l2u_update_tag_en      = '0;
    l2u_update_tag_valid   = 1'b0;
    l2u_update_tag_value   = '0;
    l2u_update_dirty_en    = '0;
    l2u_update_dirty_value = 1'b0;
    l2u_update_lru_en      = 1'b0;
    l2u_update_lru_hit_way = '0;
    w_wb_push              = 1'b0;
    w_wb_push_entry        = '0;
    if (l2t_request_valid && l2t_l2_fill) begin
      // LRU was already touched by the tag stage when it picked the victim.
      l2u_update_tag_en      = l2_idx_to_oh(l2t_fill_way);
      l2u_update_tag_valid   = 1'b1;
      l2u_update_tag_value   = l2t_request.adress.tag;
      l2u_update_dirty_en    = l2_idx_to_oh(l2t_fill_way);
      l2u_update_dirty_value = (l2t_request.packet_type == L2REQ_STORE);
      if (l2t_valid[l2t_fill_way] && l2t_dirty[l2t_fill_way]) begin
        w_wb_push       = 1'b1;
        w_wb_push_entry = '{tag:     l2t_tag[l2t_fill_way],
                            set_idx: l2t_request.adress.set_idx,
                            way:     l2t_fill_way};
      end
    end else if (w_hit) begin
      case (l2t_request.packet_type)
        L2REQ_LOAD: begin
          l2u_update_lru_en      = 1'b1;
          l2u_update_lru_hit_way = w_hit_way;
        end
        L2REQ_STORE: begin
          l2u_update_dirty_en    = l2_idx_to_oh(w_hit_way);
          l2u_update_dirty_value = 1'b1;
          l2u_update_lru_en      = 1'b1;
          l2u_update_lru_hit_way = w_hit_way;
        end
        L2REQ_FLUSH: begin
          if (l2t_dirty[w_hit_way]) begin
            w_wb_push           = 1'b1;
            w_wb_push_entry     = '{tag:     l2t_request.adress.tag,
                                    set_idx: l2t_request.adress.set_idx,
                                    way:     w_hit_way};
            l2u_update_dirty_en = l2_idx_to_oh(w_hit_way);
          end
        end
        L2REQ_DINVALIDATE: begin
          l2u_update_tag_en = l2_idx_to_oh(w_hit_way);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_request_valid <= 1'b0;
      r_hit           <= 1'b0;
      r_hit_way       <= '0;
    end else begin
      r_request_valid <= l2t_request_valid;
      r_hit           <= w_hit;
      r_hit_way       <= w_resp_way;
    end
  end

  assign l2u_request_valid = r_request_valid;
  assign l2u_hit           = r_hit;
  assign l2u_hit_way       = r_hit_way;

  l2_writeback_queue #(
    .DEPTH              (WB_QUEUE_DEPTH),
    .ALMOST_FULL_MARGIN (WB_ALMOST_FULL_MARGIN)
  ) u_wb_queue (
    .clk           (clk),
    .reset         (reset),
    .i_push        (w_wb_push),
    .i_push_entry  (w_wb_push_entry),
    .o_valid       (l2u_wb_valid),
    .o_entry       (l2u_wb_entry),
    .i_ready       (l2u_wb_ready),
    .o_almost_full (l2u_wb_almost_full)
  );

  a_single_hit: assert property (@(posedge clk) disable iff (reset)
                                 l2t_request_valid |-> $onehot0(w_hit_vec));

endmodule

// File: tb/tb_l2_cache_meta_update_stage.sv
// Bench for l2_cache_meta_update_stage: vector table for update/hit behaviour plus
// writeback-queue sequences checked against a scoreboard queue.
module tb_l2_cache_meta_update_stage;
  import l2_cache_meta_update_stage_pkg::*;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned MARGIN = 3;

  typedef struct packed {
    logic               req_valid;
    l2req_packet_type_t ptype;
    l2_tag_t            tag;
    l2_set_idx_t        set;
    logic [3:0]         valid;
    l2_tag_t [3:0]      way_tags;
    logic [3:0]         dirty;
    logic               fill;
    l2_way_idx_t        fill_way;
    logic               ready;
    logic [3:0]         e_tag_en;
    logic               e_tag_valid;
    l2_tag_t            e_tag_value;
    logic [3:0]         e_dirty_en;
    logic               e_dirty_value;
    logic               e_lru_en;
    l2_way_idx_t        e_lru_way;
    logic               e_hit;
    l2_way_idx_t        e_hit_way;
    logic               e_push;
    l2_wb_entry_t       e_wb;
  } vec_t;

  logic                  clk;
  logic                  reset;
  logic                  l2t_request_valid;
  l2req_packet_t         l2t_request;
  logic [L2_WAYS-1:0]    l2t_valid;
  l2_tag_t [L2_WAYS-1:0] l2t_tag;
  logic [L2_WAYS-1:0]    l2t_dirty;
  logic                  l2t_l2_fill;
  l2_way_idx_t           l2t_fill_way;
  logic [L2_WAYS-1:0]    l2u_update_tag_en;
  l2_set_idx_t           l2u_update_tag_set;
  logic                  l2u_update_tag_valid;
  l2_tag_t               l2u_update_tag_value;
  logic [L2_WAYS-1:0]    l2u_update_dirty_en;
  l2_set_idx_t           l2u_update_dirty_set;
  logic                  l2u_update_dirty_value;
  logic                  l2u_update_lru_en;
  l2_way_idx_t           l2u_update_lru_hit_way;
  logic                  l2u_request_valid;
  logic                  l2u_hit;
  l2_way_idx_t           l2u_hit_way;
  logic                  l2u_wb_valid;
  l2_wb_entry_t          l2u_wb_entry;
  logic                  l2u_wb_ready;
  logic                  l2u_wb_almost_full;

  int           n_checks;
  int           n_errors;
  l2_wb_entry_t sb[$];
  vec_t         vecs[11];

  l2_cache_meta_update_stage #(
    .WB_QUEUE_DEPTH        (DEPTH),
    .WB_ALMOST_FULL_MARGIN (MARGIN)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .l2t_request_valid      (l2t_request_valid),
    .l2t_request            (l2t_request),
    .l2t_valid              (l2t_valid),
    .l2t_tag                (l2t_tag),
    .l2t_dirty              (l2t_dirty),
    .l2t_l2_fill            (l2t_l2_fill),
    .l2t_fill_way           (l2t_fill_way),
    .l2u_update_tag_en      (l2u_update_tag_en),
    .l2u_update_tag_set     (l2u_update_tag_set),
    .l2u_update_tag_valid   (l2u_update_tag_valid),
    .l2u_update_tag_value   (l2u_update_tag_value),
    .l2u_update_dirty_en    (l2u_update_dirty_en),
    .l2u_update_dirty_set   (l2u_update_dirty_set),
    .l2u_update_dirty_value (l2u_update_dirty_value),
    .l2u_update_lru_en      (l2u_update_lru_en),
    .l2u_update_lru_hit_way (l2u_update_lru_hit_way),
    .l2u_request_valid      (l2u_request_valid),
    .l2u_hit                (l2u_hit),
    .l2u_hit_way            (l2u_hit_way),
    .l2u_wb_valid           (l2u_wb_valid),
    .l2u_wb_entry           (l2u_wb_entry),
    .l2u_wb_ready           (l2u_wb_ready),
    .l2u_wb_almost_full     (l2u_wb_almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk_base(input logic ready);
    vec_t v;
    v          = '0;
    v.way_tags = {16'h0a00, 16'h0b00, 16'h0c00, 16'h0d00};
    v.ready    = ready;
    return v;
  endfunction

  // Fill with victim in way fw; expectation derived from the fill rules.
  function automatic vec_t mk_fill(input l2_set_idx_t set, input l2_way_idx_t fw,
                                   input l2_tag_t new_tag, input l2_tag_t victim,
                                   input logic store, input logic vdirty, input logic ready);
    vec_t       v;
    logic [3:0] oh;
    oh                = 4'(1) << fw;
    v                 = mk_base(ready);
    v.req_valid       = 1'b1;
    v.ptype           = store ? L2REQ_STORE : L2REQ_LOAD;
    v.tag             = new_tag;
    v.set             = set;
    v.fill            = 1'b1;
    v.fill_way        = fw;
    v.valid           = oh;
    v.way_tags[fw]    = victim;
    v.dirty           = vdirty ? oh : 4'b0000;
    v.e_tag_en        = oh;
    v.e_tag_valid     = 1'b1;
    v.e_tag_value     = new_tag;
    v.e_dirty_en      = oh;
    v.e_dirty_value   = store;
    v.e_hit_way       = fw;
    v.e_push          = vdirty;
    v.e_wb.tag        = victim;
    v.e_wb.set_idx    = set;
    v.e_wb.way        = fw;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    l2t_request_valid               = v.req_valid;
    l2t_request.packet_type         = v.ptype;
    l2t_request.adress.tag          = v.tag;
    l2t_request.adress.set_idx      = v.set;
    l2t_valid                       = v.valid;
    l2t_tag                         = v.way_tags;
    l2t_dirty                       = v.dirty;
    l2t_l2_fill                     = v.fill;
    l2t_fill_way                    = v.fill_way;
    l2u_wb_ready                    = v.ready;
  endtask

  // The head is consumed on the coming edge when valid and ready are both high.
  task automatic check_head(input string lbl);
    l2_wb_entry_t exp;
    if (l2u_wb_valid && l2u_wb_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s.wb_unexpected: got entry 0x%0h expected no entry", lbl, l2u_wb_entry);
      end else begin
        exp = sb.pop_front();
        chk({lbl, ".wb_entry"}, 64'(l2u_wb_entry), 64'(exp));
      end
    end
  endtask

  task automatic check_queue(input string lbl);
    chk({lbl, ".wb_valid"}, 64'(l2u_wb_valid), 64'(sb.size() != 0));
    chk({lbl, ".wb_almost_full"}, 64'(l2u_wb_almost_full), 64'((DEPTH - sb.size()) <= MARGIN));
  endtask

  task automatic run_vec(input vec_t v, input string lbl0, input int idx);
    string lbl;
    lbl = $sformatf("%s%0d", lbl0, idx);
    @(negedge clk);
    reset = 1'b0;
    drive(v);
    #1;
    check_head(lbl);
    chk({lbl, ".tag_en"}, 64'(l2u_update_tag_en), 64'(v.e_tag_en));
    chk({lbl, ".dirty_en"}, 64'(l2u_update_dirty_en), 64'(v.e_dirty_en));
    chk({lbl, ".lru_en"}, 64'(l2u_update_lru_en), 64'(v.e_lru_en));
    chk({lbl, ".tag_set"}, 64'(l2u_update_tag_set), 64'(v.set));
    chk({lbl, ".dirty_set"}, 64'(l2u_update_dirty_set), 64'(v.set));
    if (v.e_tag_en != 4'b0000) begin
      chk({lbl, ".tag_valid"}, 64'(l2u_update_tag_valid), 64'(v.e_tag_valid));
      if (v.e_tag_valid) chk({lbl, ".tag_value"}, 64'(l2u_update_tag_value), 64'(v.e_tag_value));
    end
    if (v.e_dirty_en != 4'b0000)
      chk({lbl, ".dirty_value"}, 64'(l2u_update_dirty_value), 64'(v.e_dirty_value));
    if (v.e_lru_en)
      chk({lbl, ".lru_way"}, 64'(l2u_update_lru_hit_way), 64'(v.e_lru_way));
    if (v.e_push) sb.push_back(v.e_wb);
    @(posedge clk);
    #1;
    chk({lbl, ".req_valid_q"}, 64'(l2u_request_valid), 64'(v.req_valid));
    chk({lbl, ".hit_q"}, 64'(l2u_hit), 64'(v.e_hit));
    chk({lbl, ".hit_way_q"}, 64'(l2u_hit_way), 64'(v.e_hit_way));
    check_queue(lbl);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    drive(mk_base(1'b0));

    // Load hit way 2, set 5
    vecs[0] = mk_base(1'b1);
    vecs[0].req_valid = 1'b1; vecs[0].ptype = L2REQ_LOAD; vecs[0].tag = 16'h1234; vecs[0].set = 6'd5;
    vecs[0].valid = 4'b0100; vecs[0].way_tags[2] = 16'h1234;
    vecs[0].e_lru_en = 1'b1; vecs[0].e_lru_way = 2'd2; vecs[0].e_hit = 1'b1; vecs[0].e_hit_way = 2'd2;
    // Store hit way 1, set 9
    vecs[1] = mk_base(1'b1);
    vecs[1].req_valid = 1'b1; vecs[1].ptype = L2REQ_STORE; vecs[1].tag = 16'h2222; vecs[1].set = 6'd9;
    vecs[1].valid = 4'b0010; vecs[1].way_tags[1] = 16'h2222;
    vecs[1].e_dirty_en = 4'b0010; vecs[1].e_dirty_value = 1'b1;
    vecs[1].e_lru_en = 1'b1; vecs[1].e_lru_way = 2'd1; vecs[1].e_hit = 1'b1; vecs[1].e_hit_way = 2'd1;
    // Store fill into way 3 evicting dirty 0xABC
    vecs[2] = mk_fill(6'd7, 2'd3, 16'h0055, 16'h0abc, 1'b1, 1'b1, 1'b1);
    // Flush hit on dirty way 0
    vecs[3] = mk_base(1'b1);
    vecs[3].req_valid = 1'b1; vecs[3].ptype = L2REQ_FLUSH; vecs[3].tag = 16'h0777; vecs[3].set = 6'd12;
    vecs[3].valid = 4'b0001; vecs[3].dirty = 4'b0001; vecs[3].way_tags[0] = 16'h0777;
    vecs[3].e_dirty_en = 4'b0001; vecs[3].e_dirty_value = 1'b0;
    vecs[3].e_hit = 1'b1; vecs[3].e_hit_way = 2'd0;
    vecs[3].e_push = 1'b1; vecs[3].e_wb.tag = 16'h0777; vecs[3].e_wb.set_idx = 6'd12; vecs[3].e_wb.way = 2'd0;
    // Flush hit on clean way 2 while other ways are dirty
    vecs[4] = mk_base(1'b1);
    vecs[4].req_valid = 1'b1; vecs[4].ptype = L2REQ_FLUSH; vecs[4].tag = 16'h0b00; vecs[4].set = 6'd20;
    vecs[4].valid = 4'b0100; vecs[4].dirty = 4'b1011;
    vecs[4].e_hit = 1'b1; vecs[4].e_hit_way = 2'd2;
    // Flush miss
    vecs[5] = mk_base(1'b1);
    vecs[5].req_valid = 1'b1; vecs[5].ptype = L2REQ_FLUSH; vecs[5].tag = 16'h9999; vecs[5].set = 6'd3;
    vecs[5].valid = 4'b1111; vecs[5].dirty = 4'b1111;
    // DINVALIDATE hit way 3
    vecs[6] = mk_base(1'b1);
    vecs[6].req_valid = 1'b1; vecs[6].ptype = L2REQ_DINVALIDATE; vecs[6].tag = 16'h0a00; vecs[6].set = 6'd40;
    vecs[6].valid = 4'b1000; vecs[6].dirty = 4'b1000;
    vecs[6].e_tag_en = 4'b1000; vecs[6].e_tag_valid = 1'b0;
    vecs[6].e_hit = 1'b1; vecs[6].e_hit_way = 2'd3;
    // Load miss
    vecs[7] = mk_base(1'b1);
    vecs[7].req_valid = 1'b1; vecs[7].ptype = L2REQ_LOAD; vecs[7].tag = 16'h4321; vecs[7].set = 6'd63;
    vecs[7].valid = 4'b1111; vecs[7].dirty = 4'b1111;
    // Matching tags but no request: everything quiet
    vecs[8] = mk_base(1'b1);
    vecs[8].req_valid = 1'b0; vecs[8].ptype = L2REQ_STORE; vecs[8].tag = 16'h0b00; vecs[8].set = 6'd17;
    vecs[8].valid = 4'b0100; vecs[8].dirty = 4'b0100;
    // Load fill to clean way 1 while way 0 holds the incoming tag: no hit reported
    vecs[9] = mk_fill(6'd33, 2'd1, 16'h0c0c, 16'h3333, 1'b0, 1'b0, 1'b1);
    vecs[9].valid[0] = 1'b1; vecs[9].way_tags[0] = 16'h0c0c;
    // Store miss
    vecs[10] = mk_base(1'b1);
    vecs[10].req_valid = 1'b1; vecs[10].ptype = L2REQ_STORE; vecs[10].tag = 16'h6666; vecs[10].set = 6'd1;
    vecs[10].valid = 4'b1111;

    repeat (2) @(posedge clk);
    #1;
    chk("reset.req_valid_q", 64'(l2u_request_valid), 64'(0));
    chk("reset.hit_q", 64'(l2u_hit), 64'(0));
    chk("reset.hit_way_q", 64'(l2u_hit_way), 64'(0));
    chk("reset.wb_valid", 64'(l2u_wb_valid), 64'(0));
    chk("reset.wb_almost_full", 64'(l2u_wb_almost_full), 64'(0));

    for (int i = 0; i < 11; i++) run_vec(vecs[i], "vec", i);
    for (int i = 0; i < 3; i++) run_vec(mk_base(1'b1), "settle", i);

    // Fill the queue to 5 with the consumer stalled
    for (int i = 0; i < 5; i++)
      run_vec(mk_fill(6'(i + 1), 2'(i), 16'h7000, 16'(16'h0100 + i), 1'b0, 1'b1, 1'b0), "stall", i);
    chk("af_after_5", 64'(l2u_wb_almost_full), 64'(1));
    run_vec(mk_fill(6'd50, 2'd2, 16'h7001, 16'h0200, 1'b1, 1'b1, 1'b1), "poppush", 0);
    chk("af_pop_push", 64'(l2u_wb_almost_full), 64'(1));
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      run_vec(mk_base(1'b1), "drain", i);
    end
    chk("drain_left", 64'(sb.size()), 64'(0));
    chk("drain_wb_valid", 64'(l2u_wb_valid), 64'(0));

    // Reset with three entries queued
    for (int i = 0; i < 3; i++)
      run_vec(mk_fill(6'(i + 10), 2'(3 - i), 16'h7100, 16'(16'h0300 + i), 1'b1, 1'b1, 1'b0), "prerst", i);
    @(negedge clk);
    reset = 1'b1;
    drive(vecs[0]);
    @(posedge clk);
    #1;
    chk("rst.wb_valid", 64'(l2u_wb_valid), 64'(0));
    chk("rst.wb_almost_full", 64'(l2u_wb_almost_full), 64'(0));
    chk("rst.req_valid_q", 64'(l2u_request_valid), 64'(0));
    chk("rst.hit_q", 64'(l2u_hit), 64'(0));
    sb.delete();
    run_vec(mk_base(1'b1), "postrst", 0);
    run_vec(vecs[0], "postrst", 1);
    run_vec(vecs[2], "postrst", 2);
    run_vec(mk_base(1'b1), "postrst", 3);
    run_vec(mk_base(1'b1), "postrst", 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
